serial_frame_rx: RTL
====================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter PARITY_EN, default 1: 1 = frame carries an even-parity bit after the data; 0 = no parity bit.
REQ-002 CLK  input  1  clock; all state changes on the rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 CLR  input  1  synchronous clear: aborts the current frame, clears the error flags and FRAME_COUNT.
REQ-005 SI  input  1  serial line, driven by the upstream shift register's SERIAL_OUT.
REQ-006 EN  input  1  bit-sample enable; the receiver samples SI and advances only on edges where EN=1.
REQ-007 MSB_FIRST  input  1  bit order for the frame being started.
REQ-008 PARALLEL_OUT  output  [0:3]  last correctly received word.
REQ-009 VALID  output  1  one-cycle pulse: PARALLEL_OUT has just been updated.
REQ-010 PARITY_ERR  output  1  sticky flag: a frame failed the parity check.
REQ-011 FRAME_ERR  output  1  sticky flag: a frame had a bad stop bit.
REQ-012 BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-013 FRAME_COUNT  output  [7:0]  count of good frames.

Function
REQ-014 Frame format, in order: idle line = 0, start bit = 1, 4 data bits, parity bit (only if PARITY_EN=1), stop bit = 0.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-016 Edges with EN=0 SHALL hold the state, the bit counter and the shift contents unchanged in every state.
REQ-017 IDLE -> DATA on an edge with EN=1 and SI=1; MSB_FIRST is latched on that edge and held for the whole frame.
REQ-018 DATA captures one bit per enabled edge; a 2-bit counter selects the slot.
REQ-019 With MSB_FIRST=1, the first data bit goes to [0] and the fourth to [3]; with MSB_FIRST=0, the first goes to [3] and the fourth to [0].
REQ-020 After the 4th data bit, DATA -> PARITY if PARITY_EN=1, otherwise DATA -> STOP.
REQ-021 PARITY samples one bit on its enabled edge, then -> STOP; parity is good when the XOR of the 4 data bits and the parity bit is 0.
REQ-022 STOP samples the stop bit on its enabled edge, then -> IDLE unconditionally; there is no back-to-back start detection on that same edge.
REQ-023 Completion on the STOP edge, stop bit 0 and parity good: PARALLEL_OUT <= captured word, VALID = 1 for exactly the next cycle, FRAME_COUNT += 1.
REQ-024 Completion with stop bit 1: FRAME_ERR <= 1, no VALID, PARALLEL_OUT and FRAME_COUNT unchanged.
REQ-025 Completion with parity bad: PARITY_ERR <= 1, no VALID, PARALLEL_OUT and FRAME_COUNT unchanged; both flags set if both errors occur.
REQ-026 FRAME_COUNT SHALL wrap from 255 to 0 without any flag.
REQ-027 Latency: VALID rises one clock after the edge that samples the stop bit.
REQ-028 CLR=1 on an edge (RST=0): FSM -> IDLE, PARITY_ERR = FRAME_ERR = 0, FRAME_COUNT = 0, VALID = 0, PARALLEL_OUT retained. CLR overrides a completion on the same edge.
REQ-029 BUSY SHALL be a registered function of the state: 1 in DATA, PARITY and STOP, 0 in IDLE.

Reset
REQ-030 RST=1 on an edge SHALL force IDLE, PARALLEL_OUT = 0000, VALID = 0, PARITY_ERR = 0, FRAME_ERR = 0, BUSY = 0, FRAME_COUNT = 0, and bit counter = 0.
REQ-031 RST SHALL take priority over CLR and EN.
REQ-032 RST asserted mid-frame SHALL abort the frame with no VALID pulse.

Verification
REQ-033 Hold RST for 2 cycles -> every output is 0 and the FSM is in IDLE.
REQ-034 PARITY_EN=1, EN=1, MSB_FIRST=1, SI = 1,1,0,1,0,0,0 on successive edges -> PARALLEL_OUT[0:3] = 1010, VALID pulses for one cycle, FRAME_COUNT = 1, no flags.
REQ-035 Same SI stream with MSB_FIRST=0 -> PARALLEL_OUT[0:3] = 0101 and FRAME_COUNT increments.
REQ-036 Same stream but parity bit = 1 -> PARITY_ERR = 1, no VALID, PARALLEL_OUT and FRAME_COUNT unchanged; then a stop bit of 1 in the next frame -> FRAME_ERR = 1; then CLR -> both flags 0 and FRAME_COUNT = 0.
REQ-037 REQ-034 stream with EN alternating 1/0 -> identical result, BUSY high throughout; RST pulsed during DATA -> IDLE on the next cycle, no VALID, outputs at reset values.
REQ-038 256 good frames -> FRAME_COUNT wraps to 0, and each frame produces exactly one VALID pulse.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/parity/stop serial receiver.
// Frame on SI: idle 0, start 1, 4 data bits, optional even parity, stop 0.
// The receiver only looks at SI on edges where EN=1, so one external
// enable can pace it to any bit rate.
module serial_frame_rx #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       SI,
  input  logic       EN,
  input  logic       MSB_FIRST,
  output logic [0:3] PARALLEL_OUT,
  output logic       VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BUSY,
  output logic [7:0] FRAME_COUNT
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t     r_state;
  logic [1:0] r_cnt;    // data slot counter, wraps to 0 after the 4th bit
  logic [0:3] r_shift;  // word being assembled
  logic       r_msb;    // bit order latched at the start bit
  logic       r_pbad;   // parity verdict carried into STOP

  logic [1:0] w_slot;
  logic       w_par_bad;

  // MSB-first fills [0]..[3]; LSB-first fills [3]..[0].
  assign w_slot    = r_msb ? r_cnt : ~r_cnt;
  // Even parity: data bits XOR parity bit must be 0.
  assign w_par_bad = (^r_shift) ^ SI;

  // Receiver FSM with registered outputs; RST beats CLR beats normal operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_cnt        <= 2'd0;
      r_shift      <= 4'b0000;
      r_msb        <= 1'b0;
      r_pbad       <= 1'b0;
      PARALLEL_OUT <= 4'b0000;
      VALID        <= 1'b0;
      PARITY_ERR   <= 1'b0;
      FRAME_ERR    <= 1'b0;
      BUSY         <= 1'b0;
      FRAME_COUNT  <= 8'd0;
    end else if (CLR) begin
      // Abort the frame and clear status; the last good word is kept.
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_pbad      <= 1'b0;
      VALID       <= 1'b0;
      PARITY_ERR  <= 1'b0;
      FRAME_ERR   <= 1'b0;
      BUSY        <= 1'b0;
      FRAME_COUNT <= 8'd0;
    end else begin
      VALID <= 1'b0;
      if (EN) begin
        case (r_state)
          IDLE: begin
            if (SI) begin
              r_state <= DATA;
              BUSY    <= 1'b1;
              r_msb   <= MSB_FIRST;
              r_cnt   <= 2'd0;
              r_pbad  <= 1'b0;
            end
          end
          DATA: begin
            r_shift[w_slot] <= SI;
            r_cnt           <= r_cnt + 2'd1;
            if (r_cnt == 2'd3)
              r_state <= PARITY_EN ? PARITY : STOP;
          end
          PARITY: begin
            r_pbad  <= w_par_bad;
            r_state <= STOP;
          end
          STOP: begin
            // Always return to IDLE; a start bit is not looked for on this edge.
            r_state <= IDLE;
            BUSY    <= 1'b0;
            if (SI)
              FRAME_ERR <= 1'b1;
            if (r_pbad)
              PARITY_ERR <= 1'b1;
            if (!SI && !r_pbad) begin
              PARALLEL_OUT <= r_shift;
              VALID        <= 1'b1;
              FRAME_COUNT  <= FRAME_COUNT + 8'd1;
            end
          end
          default: begin
            r_state <= IDLE;
            BUSY    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
